motion_arbiter: RTL and testbench



---
 rtl/motion_arbiter.sv | 138 +++++++++++++
 tb/tb_motion_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_arbiter.sv
// Round-robin arbiter sharing one motion/collision engine
// among player 1, player 2 and the cannon.
module motion_arbiter #(
  parameter int X_W     = 11,
  parameter int Y_W     = 10,
  parameter int TIMEOUT = 15
) (
  input  logic           clk_slow,
  input  logic           rst_n,
  input  logic [2:0]     req,
  input  logic [X_W-1:0] p1_x,
  input  logic [Y_W-1:0] p1_y,
  input  logic [X_W-1:0] p2_x,
  input  logic [Y_W-1:0] p2_y,
  input  logic [X_W-1:0] cn_x,
  input  logic [Y_W-1:0] cn_y,
  input  logic           eng_done,
  input  logic [3:0]     eng_state,
  output logic           eng_start,
  output logic [X_W-1:0] eng_x,
  output logic [Y_W-1:0] eng_y,
  output logic [2:0]     grant,
  output logic [2:0]     result_valid,
  output logic [3:0]     result_state,
  output logic           busy,
  output logic           timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DELIVER
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nx;
  logic [1:0] last;
  logic [1:0] idx;
  logic [1:0] sel;
  logic [7:0] cnt;
  logic       expire;

  assign expire = (cnt == CNT_LAST);
  assign busy   = (state != IDLE);

  // search starts just after the last requester served
  always_comb begin
    sel = 2'd0;
    unique case (last)
      2'd0: sel = req[1] ? 2'd1 :
                  req[2] ? 2'd2 : 2'd0;
      2'd1: sel = req[2] ? 2'd2 :
                  req[0] ? 2'd0 : 2'd1;
      default: sel = req[0] ? 2'd0 :
                     req[1] ? 2'd1 : 2'd2;
    endcase
  end

  always_ff @(posedge clk_slow) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (|req) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (eng_done || expire)
                 state_nx = DELIVER;
      DELIVER: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_slow) begin
    if (!rst_n) begin
      eng_start    <= 1'b0;
      eng_x        <= '0;
      eng_y        <= '0;
      grant        <= 3'b000;
      result_valid <= 3'b000;
      result_state <= 4'h0;
      timeout_err  <= 1'b0;
      last         <= 2'd2;
      idx          <= 2'd0;
      cnt          <= 8'd0;
    end else begin
      eng_start    <= 1'b0;
      result_valid <= 3'b000;
      unique case (state)
        IDLE: begin
          if (|req) begin
            grant     <= 3'(1 << sel);
            idx       <= sel;
            eng_start <= 1'b1;
            unique case (sel)
              2'd0: begin
                eng_x <= p1_x;
                eng_y <= p1_y;
              end
              2'd1: begin
                eng_x <= p2_x;
                eng_y <= p2_y;
              end
              default: begin
                eng_x <= cn_x;
                eng_y <= cn_y;
              end
            endcase
          end
        end
        ISSUE: cnt <= 8'd0;
        WAIT: begin
          // a late done still beats the abort
          if (eng_done) begin
            result_state <= eng_state;
            result_valid <= grant;
            grant        <= 3'b000;
          end else if (expire) begin
            result_state <= 4'h0;
            result_valid <= grant;
            grant        <= 3'b000;
            timeout_err  <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DELIVER: last <= idx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_motion_arbiter.sv
// Randomized bench for motion_arbiter against a
// transaction-level round-robin model.
module tb_motion_arbiter;

  localparam int XW = 11;
  localparam int YW = 10;
  localparam int TO = 15;

  logic          clk_slow = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    req = 3'b000;
  logic [XW-1:0] p1_x = '0;
  logic [YW-1:0] p1_y = '0;
  logic [XW-1:0] p2_x = '0;
  logic [YW-1:0] p2_y = '0;
  logic [XW-1:0] cn_x = '0;
  logic [YW-1:0] cn_y = '0;
  logic          eng_done = 1'b0;
  logic [3:0]    eng_state = 4'h0;
  logic          eng_start;
  logic [XW-1:0] eng_x;
  logic [YW-1:0] eng_y;
  logic [2:0]    grant;
  logic [2:0]    result_valid;
  logic [3:0]    result_state;
  logic          busy;
  logic          timeout_err;

  int vectors = 0;
  int miscompares = 0;
  int m_last = 2;
  bit m_terr = 1'b0;

  motion_arbiter #(
    .X_W(XW),
    .Y_W(YW),
    .TIMEOUT(TO)
  ) dut (
    .clk_slow(clk_slow),
    .rst_n(rst_n),
    .req(req),
    .p1_x(p1_x),
    .p1_y(p1_y),
    .p2_x(p2_x),
    .p2_y(p2_y),
    .cn_x(cn_x),
    .cn_y(cn_y),
    .eng_done(eng_done),
    .eng_state(eng_state),
    .eng_start(eng_start),
    .eng_x(eng_x),
    .eng_y(eng_y),
    .grant(grant),
    .result_valid(result_valid),
    .result_state(result_state),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk_slow = ~clk_slow;

  function automatic int pick(input logic [2:0] r,
                              input int last);
    int i;
    for (int k = 1; k <= 3; k++) begin
      i = (last + k) % 3;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk_slow);
    #1;
  endtask

  task automatic rand_coords;
    p1_x = XW'($urandom);
    p1_y = YW'($urandom);
    p2_x = XW'($urandom);
    p2_y = YW'($urandom);
    cn_x = XW'($urandom);
    cn_y = YW'($urandom);
  endtask

  // one full transaction; delay >= TO means no done
  task automatic run_txn(input logic [2:0] r,
                         input int delay,
                         input logic [3:0] st,
                         input bit stray);
    int s;
    int w;
    bit to;
    logic [2:0] oh;
    logic [3:0] exp_st;
    logic [XW-1:0] ex;
    logic [YW-1:0] ey;
    req = r;
    s = pick(r, m_last);
    oh = 3'(1 << s);
    case (s)
      0: begin ex = p1_x; ey = p1_y; end
      1: begin ex = p2_x; ey = p2_y; end
      default: begin ex = cn_x; ey = cn_y; end
    endcase
    tick;
    vectors++;
    if ({eng_start, busy, grant, result_valid, eng_x, eng_y}
        !== {1'b1, 1'b1, oh, 3'b000, ex, ey}) begin
      miscompares++;
      $display("FAIL issue: got st=%b bz=%b g=%b rv=%b x=%0d y=%0d want g=%b x=%0d y=%0d",
               eng_start, busy, grant, result_valid,
               eng_x, eng_y, oh, ex, ey);
    end
    req = 3'($urandom);
    rand_coords;
    if (stray) begin
      eng_done = 1'b1;
      eng_state = 4'($urandom);
    end
    tick;
    eng_done = 1'b0;
    vectors++;
    if ({eng_start, busy, grant, result_valid, eng_x, eng_y}
        !== {1'b0, 1'b1, oh, 3'b000, ex, ey}) begin
      miscompares++;
      $display("FAIL wait_entry: got st=%b bz=%b g=%b rv=%b x=%0d y=%0d want g=%b x=%0d y=%0d",
               eng_start, busy, grant, result_valid,
               eng_x, eng_y, oh, ex, ey);
    end
    to = (delay >= TO);
    for (w = 0; w < TO; w++) begin
      rand_coords;
      if (w == delay) begin
        eng_done = 1'b1;
        eng_state = st;
      end
      tick;
      eng_done = 1'b0;
      eng_state = 4'($urandom);
      if (w == delay || w == TO - 1) break;
      vectors++;
      if ({eng_start, busy, grant, result_valid, eng_x, eng_y}
          !== {1'b0, 1'b1, oh, 3'b000, ex, ey}) begin
        miscompares++;
        $display("FAIL wait_%0d: got g=%b rv=%b bz=%b x=%0d y=%0d want g=%b x=%0d y=%0d",
                 w, grant, result_valid, busy,
                 eng_x, eng_y, oh, ex, ey);
      end
    end
    if (to) m_terr = 1'b1;
    exp_st = to ? 4'h0 : st;
    vectors++;
    if ({result_valid, result_state, grant, busy, timeout_err}
        !== {oh, exp_st, 3'b000, 1'b1, m_terr}) begin
      miscompares++;
      $display("FAIL deliver: got rv=%b rs=%h g=%b bz=%b te=%b want rv=%b rs=%h te=%b",
               result_valid, result_state, grant, busy,
               timeout_err, oh, exp_st, m_terr);
    end
    tick;
    m_last = s;
    vectors++;
    if ({result_valid, busy, grant, eng_start,
         result_state, timeout_err}
        !== {3'b000, 1'b0, 3'b000, 1'b0, exp_st, m_terr}) begin
      miscompares++;
      $display("FAIL idle_after: got rv=%b bz=%b g=%b st=%b rs=%h te=%b want rs=%h te=%b",
               result_valid, busy, grant, eng_start,
               result_state, timeout_err, exp_st, m_terr);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req = 3'b111;
    eng_done = 1'b1;
    rand_coords;
    tick;
    tick;
    vectors++;
    if ({eng_start, eng_x, eng_y, grant, result_valid,
         result_state, busy, timeout_err} !== '0) begin
      miscompares++;
      $display("FAIL reset: got st=%b x=%0d y=%0d g=%b rv=%b rs=%h bz=%b te=%b want all 0",
               eng_start, eng_x, eng_y, grant, result_valid,
               result_state, busy, timeout_err);
    end
    rst_n = 1'b1;
    req = 3'b000;
    eng_done = 1'b0;
    m_last = 2;
    m_terr = 1'b0;
    tick;
  endtask

  task automatic test_round_robin;
    for (int i = 0; i < 4; i++) run_txn(3'b111, 0, 4'h5, 1'b0);
  endtask

  task automatic test_capture;
    rand_coords;
    cn_x = 11'd700;
    cn_y = 10'd300;
    run_txn(3'b100, 2, 4'($urandom), 1'b0);
  endtask

  task automatic test_done_at_limit;
    run_txn(3'b001, TO - 1, 4'hA, 1'b0);
  endtask

  task automatic test_stray;
    req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      eng_done = 1'b1;
      eng_state = 4'($urandom);
      tick;
      vectors++;
      if ({busy, grant, result_valid, eng_start} !== '0) begin
        miscompares++;
        $display("FAIL stray_idle: got bz=%b g=%b rv=%b st=%b want 0",
                 busy, grant, result_valid, eng_start);
      end
    end
    eng_done = 1'b0;
    run_txn(3'b111, 1, 4'($urandom), 1'b1);
  endtask

  task automatic test_timeout;
    run_txn(3'b010, TO + 5, 4'h3, 1'b0);
    for (int i = 0; i < 3; i++)
      run_txn(3'b111, i, 4'($urandom), 1'b0);
  endtask

  task automatic test_random;
    logic [2:0] r;
    for (int i = 0; i < 25; i++) begin
      r = 3'($urandom_range(1, 7));
      rand_coords;
      run_txn(r, int'($urandom_range(0, TO + 2)),
              4'($urandom), 1'($urandom));
      req = 3'b000;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        tick;
        vectors++;
        if ({busy, grant, eng_start} !== '0) begin
          miscompares++;
          $display("FAIL gap: got bz=%b g=%b st=%b want 0",
                   busy, grant, eng_start);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    rand_coords;
    req = 3'b010;
    tick;
    tick;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    req = 3'b000;
    m_last = 2;
    m_terr = 1'b0;
    vectors++;
    if ({grant, busy, result_valid, eng_start, timeout_err}
        !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got g=%b bz=%b rv=%b st=%b te=%b want 0",
               grant, busy, result_valid, eng_start, timeout_err);
    end
    for (int i = 0; i < 3; i++) begin
      eng_done = (i == 1);
      eng_state = 4'h9;
      tick;
      vectors++;
      if ({result_valid, busy} !== '0) begin
        miscompares++;
        $display("FAIL late_done: got rv=%b bz=%b want 0",
                 result_valid, busy);
      end
    end
    eng_done = 1'b0;
    rand_coords;
    run_txn(3'b111, 0, 4'h6, 1'b0);
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_capture;
    test_done_at_limit;
    test_stray;
    test_timeout;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
